// File: rtl/signed_result_formatter.sv
// Formats a 6-bit two's-complement difference into sign, overflow flag and a
// two-digit BCD magnitude using one double-dabble iteration per cycle.
module signed_result_formatter (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [5:0] diff,
   input  logic       a_sign,
   input  logic       b_sign,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       neg,
   output logic       ovf,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] LAST_ITER = 3'd6;

   state_t      state_reg;
   state_t      state_next;
   logic [2:0]  cnt_reg;
   // {tens nibble, ones nibble, remaining binary magnitude}
   logic [13:0] shift_reg;
   logic [13:0] shift_next;
   logic [3:0]  tens_adj;
   logic [3:0]  ones_adj;
   logic [5:0]  mag;

   // Negating 6'b100000 wraps back to itself, which read unsigned is 32.
   always_comb begin
      mag = diff[5] ? 6'(~diff + 6'd1) : diff;
   end

   always_comb begin
      tens_adj   = (shift_reg[13:10] >= 4'd5) ? shift_reg[13:10] + 4'd3 : shift_reg[13:10];
      ones_adj   = (shift_reg[9:6]   >= 4'd5) ? shift_reg[9:6]   + 4'd3 : shift_reg[9:6];
      shift_next = {tens_adj[2:0], ones_adj, shift_reg[5:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)             state_next = CONV;
         CONV:    if (cnt_reg == LAST_ITER) state_next = DONE;
         DONE:    if (out_ready)            state_next = IDLE;
         default:                           state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   // The digit outputs are loaded only when conversion finishes, so they never
   // expose intermediate double-dabble values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg   <= 3'd0;
         shift_reg <= 14'd0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         bcd_tens  <= 4'd0;
         bcd_ones  <= 4'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  neg       <= diff[5];
                  ovf       <= (a_sign != b_sign) && (diff[5] != a_sign);
                  shift_reg <= {8'd0, mag};
                  cnt_reg   <= 3'd0;
               end
            end
            CONV: begin
               if (cnt_reg != LAST_ITER) begin
                  shift_reg <= shift_next;
                  cnt_reg   <= cnt_reg + 3'd1;
               end else begin
                  bcd_tens <= shift_reg[13:10];
                  bcd_ones <= shift_reg[9:6];
                  cnt_reg  <= 3'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_result_formatter.sv
// Randomized scoreboard bench for signed_result_formatter: accepted inputs push
// an arithmetic reference result; a monitor pops and checks each presented one.
module tb_signed_result_formatter;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] diff;
   logic       a_sign;
   logic       b_sign;
   logic       out_valid;
   logic       out_ready;
   logic       neg;
   logic       ovf;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;

   signed_result_formatter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .diff      (diff),
      .a_sign    (a_sign),
      .b_sign    (b_sign),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .neg       (neg),
      .ovf       (ovf),
      .bcd_tens  (bcd_tens),
      .bcd_ones  (bcd_ones)
   );

   typedef struct {
      logic neg;
      logic ovf;
      int   tens;
      int   ones;
      int   cap;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   int   edge_num = 0;
   int   cur_a = 0;
   int   cur_b = 0;
   exp_t q[$];
   exp_t cur;
   bit   have_cur = 0;
   bit   busy = 0;
   bit   prev_ov = 0;
   bit   prev_hs = 0;
   bit   to_flag = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_num <= edge_num + 1;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_num);
      end
   endtask

   // Reference: true difference, wrapped into 6-bit signed range.
   function automatic exp_t ref_model(input int a, input int b, input int cap);
      exp_t e;
      int d, w, m;
      d = a - b;
      w = d;
      if (w > 31)  w = w - 64;
      if (w < -32) w = w + 64;
      m = (w < 0) ? -w : w;
      e.neg  = (w < 0);
      e.ovf  = (d != w);
      e.tens = m / 10;
      e.ones = m % 10;
      e.cap  = cap;
      return e;
   endfunction

   // Monitor: samples on the falling edge, i.e. state after the last rising edge
   // and the inputs that the next rising edge will see.
   always @(negedge clk) begin
      if (!rst) begin
         chk({in_ready, out_valid, neg, ovf, bcd_tens, bcd_ones} == 12'h800, "reset_state",
             int'({in_ready, out_valid, neg, ovf, bcd_tens, bcd_ones}), 12'h800);
         q.delete();
         busy = 0; prev_ov = 0; prev_hs = 0; have_cur = 0; to_flag = 0;
      end else begin
         chk(in_ready == !busy, "in_ready", int'(in_ready), int'(!busy));
         if (prev_hs) chk(!out_valid, "out_valid_drop", int'(out_valid), 0);
         if (out_valid && !prev_ov) begin
            if (q.size() == 0) begin
               chk(1'b0, "spurious_out_valid", 1, 0);
               have_cur = 0;
            end else begin
               cur = q.pop_front();
               have_cur = 1;
               to_flag = 0;
               chk(edge_num == cur.cap + 7, "latency", edge_num - cur.cap, 7);
            end
         end
         if (out_valid && have_cur)
            chk({neg, ovf, bcd_tens, bcd_ones} == {cur.neg, cur.ovf, 4'(cur.tens), 4'(cur.ones)},
                "result", int'({neg, ovf, bcd_tens, bcd_ones}),
                int'({cur.neg, cur.ovf, 4'(cur.tens), 4'(cur.ones)}));
         if (!out_valid && q.size() > 0 && !to_flag && edge_num > q[0].cap + 7) begin
            chk(1'b0, "out_valid_timeout", edge_num - q[0].cap, 7);
            to_flag = 1;
         end
         prev_ov = out_valid;
         prev_hs = out_valid && out_ready;
         if (prev_hs) begin
            busy = 0;
            have_cur = 0;
         end
         if (in_valid && in_ready) begin
            q.push_back(ref_model(cur_a, cur_b, edge_num + 1));
            busy = 1;
         end
      end
   end

   task automatic drive_ab(input int a, input int b, input bit v);
      cur_a    = a;
      cur_b    = b;
      diff     = 6'(a - b);
      a_sign   = (a < 0);
      b_sign   = (b < 0);
      in_valid = v;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic int rnd6();
      return int'($urandom_range(0, 63)) - 32;
   endfunction

   // One transaction: junk is driven during CONV/DONE to show it is ignored.
   task automatic run_one(input int a, input int b, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) begin
         chk(1'b0, "in_ready_timeout", 0, 1);
         return;
      end
      drive_ab(a, b, 1'b1);
      out_ready = 1'b0;
      step();
      n = 0;
      while (!out_valid && n < 20) begin
         drive_ab(rnd6(), rnd6(), 1'($urandom_range(0, 1)));
         step();
         n++;
      end
      if (!out_valid) begin
         chk(1'b0, "drv_out_valid_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      repeat (hold) begin
         drive_ab(rnd6(), rnd6(), 1'($urandom_range(0, 1)));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      drive_ab(0, 0, 1'b0);
      out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1;

      run_one(5, 0, 0);
      run_one(-2, 30, 1);
      run_one(31, -2, 2);
      run_one(-10, 0, 5);

      // Reset during the third conversion cycle, then a clean capture.
      drive_ab(17, 3, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      run_one(9, 0, 0);

      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 2)) step();
         run_one(rnd6(), rnd6(), int'($urandom_range(0, 3)));
      end

      // Back-to-back stream: new inputs every cycle, consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         drive_ab(rnd6(), rnd6(), 1'b1);
         step();
      end
      in_valid = 1'b0;
      repeat (20) step();

      chk(q.size() == 0, "scoreboard_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
